// File: rtl/cpu_clock_ctrl_if.sv
// cpu_clock_ctrl_if: the button, HLT-decode and divider-load bus between the
// front panel / CPU and the clock controller, along with the controller's
// status and strobe outputs.
//   run_btn, step_btn : debounced buttons, acted on at their rising edge
//   halt_req          : one-cycle pulse from the CPU HLT instruction
//   div_wr, div_data  : load strobe and value for a new terminal count
//   cpu_en            : one-cycle CPU advance strobe
//   clock_out         : LED indicator, toggles on every cpu_en
//   running, state    : status (HALT=00, RUN=01, STEP=10)
interface cpu_clock_ctrl_if #(
    parameter int unsigned DIV_WIDTH = 18
);
    logic                 run_btn;
    logic                 step_btn;
    logic                 halt_req;
    logic                 div_wr;
    logic [DIV_WIDTH-1:0] div_data;
    logic                 cpu_en;
    logic                 clock_out;
    logic                 running;
    logic [1:0]           state;

    modport master (
        output run_btn, step_btn, halt_req, div_wr, div_data,
        input  cpu_en, clock_out, running, state
    );

    modport slave (
        input  run_btn, step_btn, halt_req, div_wr, div_data,
        output cpu_en, clock_out, running, state
    );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: run/halt/single-step clock controller for the 8-bit CPU.
// Produces a one-cycle cpu_en strobe on the system clock, either from a
// runtime-programmable divider (RUN), one per step press (STEP), or none (HALT).
//   clock_in : system clock
//   nReset   : synchronous, active-low reset
//   bus      : control/status bus (see cpu_clock_ctrl_if)
module cpu_clock_ctrl #(
    parameter int unsigned          DIV_WIDTH = 18,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(199999)
) (
    input  logic              clock_in,
    input  logic              nReset,
    cpu_clock_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] count_q, count_d;
    logic [DIV_WIDTH-1:0] div_reg_q, div_reg_d;
    logic [DIV_WIDTH-1:0] div_pend_q, div_pend_d;
    logic                 pend_q, pend_d;
    logic                 cpu_en_q, cpu_en_d;
    logic                 clock_out_q, clock_out_d;
    logic                 run_prev_q, run_prev_d;
    logic                 step_prev_q, step_prev_d;

    logic run_edge;
    logic step_edge;
    logic apply;

    assign run_edge  = bus.run_btn & ~run_prev_q;
    assign step_edge = bus.step_btn & ~step_prev_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cpu_en_d    = 1'b0;
        clock_out_d = clock_out_q;
        div_reg_d   = div_reg_q;
        div_pend_d  = div_pend_q;
        pend_d      = pend_q;
        apply       = 1'b0;
        run_prev_d  = bus.run_btn;
        step_prev_d = bus.step_btn;

        case (state_q)
            HALT: begin
                count_d = '0;
                apply   = 1'b1;
                if (bus.halt_req) begin
                    state_d = HALT;
                end else if (run_edge) begin
                    state_d = RUN;
                end else if (step_edge) begin
                    state_d     = STEP;
                    cpu_en_d    = 1'b1;
                    clock_out_d = ~clock_out_q;
                end
            end
            RUN: begin
                // Halting wins over a coincident terminal count.
                if (bus.halt_req || run_edge) begin
                    state_d = HALT;
                    count_d = '0;
                end else if (count_q == div_reg_q) begin
                    count_d     = '0;
                    cpu_en_d    = 1'b1;
                    clock_out_d = ~clock_out_q;
                    apply       = 1'b1;
                end else begin
                    count_d = count_q + DIV_WIDTH'(1);
                end
            end
            STEP: begin
                state_d = HALT;
                count_d = '0;
                apply   = 1'b1;
            end
            default: begin
                state_d = HALT;
                count_d = '0;
            end
        endcase

        // A pending value is only ever applied while count is (or becomes) 0,
        // so count can never overshoot a shrunken terminal count.
        if (apply && pend_q) begin
            div_reg_d = bus.div_wr ? bus.div_data : div_pend_q;
            pend_d    = 1'b0;
        end else if (bus.div_wr) begin
            div_pend_d = bus.div_data;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        // Button history tracks the inputs even in reset, so a button held
        // through reset release is not seen as an edge.
        run_prev_q  <= run_prev_d;
        step_prev_q <= step_prev_d;
        if (!nReset) begin
            state_q     <= HALT;
            count_q     <= '0;
            div_reg_q   <= DIV_RESET;
            div_pend_q  <= '0;
            pend_q      <= 1'b0;
            cpu_en_q    <= 1'b0;
            clock_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            div_reg_q   <= div_reg_d;
            div_pend_q  <= div_pend_d;
            pend_q      <= pend_d;
            cpu_en_q    <= cpu_en_d;
            clock_out_q <= clock_out_d;
        end
    end

    assign bus.cpu_en    = cpu_en_q;
    assign bus.clock_out = clock_out_q;
    assign bus.running   = (state_q == RUN);
    assign bus.state     = state_q;

endmodule
